m2vblkwr: RTL
=============

Name: m2vblkwr

Overview:
- Consumer end of the stage-4 side-information interface. Sits inside the motion-compensation path.
- On each block_start it latches the stage-4 macroblock position and block number.
- It then accepts the 64 reconstructed 8-bit pixels of that block in raster order, packs them 4 per 32-bit word, and issues 16 frame-memory word writes with computed 4:2:0 planar addresses over a valid/ready handshake.

Parameters:
- MBX_WIDTH, 6, width of macroblock X index (frame width = 2^MBX_WIDTH*16 pixels).
- MBY_WIDTH, 5, width of macroblock Y index.

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- block_start  input  1  one-cycle pulse; samples side info
- s4_mb_x  input  MBX_WIDTH  macroblock X
- s4_mb_y  input  MBY_WIDTH  macroblock Y
- s4_block  input  3  block number (0-3 luma, 4 Cb, 5 Cr)
- s4_enable  input  1  block valid
- pix_data  input  8  reconstructed pixel
- pix_valid  input  1  pixel present
- pix_ready  output  1  pixel accepted when pix_valid & pix_ready
- wr_addr  output  MBX_WIDTH+MBY_WIDTH+7  frame-memory word address
- wr_data  output  32  packed pixels, first pixel in [7:0]
- wr_valid  output  1  write request
- wr_ready  input  1  memory accepts when wr_valid & wr_ready
- busy  output  1  high while not IDLE
- blk_done  output  1  one-cycle pulse at block completion
- err_overrun  output  1  sticky: block_start arrived while busy

Behaviour:
- Reset: all outputs 0; state IDLE; pixel counter 0; latched side info 0.
- Interface contract: reset is asynchronous active-low (reset_n); clock is clk.
- States: IDLE, COLLECT, FLUSH.
- IDLE:
  - block_start with s4_enable=1 and s4_block<=5: latch x, y, block; clear pix_cnt (6 bits); go to COLLECT next cycle.
  - block_start with s4_enable=0 or s4_block>=6: no pixels accepted; blk_done pulses the next cycle; stay IDLE.
- COLLECT:
  - pix_ready = ~wr_valid.
  - Each accepted pixel is written into byte lane pix_cnt[1:0]; pix_cnt increments.
  - On acceptance of a pixel with pix_cnt[1:0]=3: wr_valid=1 the next cycle, wr_data=the packed word, wr_addr computed from word index k=pix_cnt[5:2]; state becomes FLUSH.
- FLUSH:
  - wr_valid, wr_addr and wr_data hold stable until wr_ready.
  - On handshake: wr_valid=0 the next cycle.
  - If k was 15: return to IDLE and pulse blk_done in that same next cycle.
  - Otherwise: return to COLLECT.
- Address fields: row r=k[3:1], word w=k[0].
- Luma (block 0-3):
  - y = mb_y*16 + block[1]*8 + r (MBY_WIDTH+4 bits).
  - cw = mb_x*4 + block[0]*2 + w (MBX_WIDTH+2 bits).
  - wr_addr = {1'b0, y, cw}.
- Chroma (block 4/5):
  - y = mb_y*8 + r (MBY_WIDTH+3 bits).
  - cw = mb_x*2 + w (MBX_WIDTH+1 bits).
  - wr_addr = {1'b1, 1'b0, block[0], y, cw}.
- No wrap-around: all arithmetic fits exactly in the field widths.
- block_start while busy: ignored (latched info and transfer unaffected); err_overrun set to 1 and held until reset.
- pix_valid while pix_ready=0: pixel not consumed; the source holds it.
- Reset mid-block: transfer abandoned immediately; wr_valid drops asynchronously; no blk_done.

Test Plan:
- Luma block 3, mb(2,1), defaults, pixels 0..63, wr_ready=1 → 16 writes; first wr_addr=6154, wr_data=0x03020100; last wr_addr=7947, wr_data=0x3F3E3D3C; blk_done once, one cycle after the 16th handshake.
- Cr block 5, mb(2,1) → first wr_addr=164868 (bit17=1, bit15=1, y=8, cw=4); last wr_addr=164868+7*128+1=165765.
- Backpressure: wr_ready held 0 for 10 cycles on word 0 → wr_valid, wr_addr and wr_data stable; pix_ready=0 throughout; no pixel lost; data correct after release.
- s4_enable=0 block_start → pix_ready stays 0, no wr_valid, blk_done pulse the next cycle; s4_block=6 behaves identically.
- block_start pulsed during COLLECT of a block 0 → err_overrun=1 and stays 1; the original block's 16 addresses are unchanged.
- reset_n asserted after 20 pixels → all outputs 0; a following block_start for block 0, mb(0,0) → first wr_addr=0.

Source files
------------

// File: rtl/m2vblkwr.sv
// Stage-4 block writer: collects one 8x8 block of reconstructed pixels,
// packs them four per word and writes the 16 words into the 4:2:0 planar
// frame memory over a valid/ready handshake.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for block_start; side info not in use
// COLLECT | accepting pixels into the packing register
// FLUSH   | one packed word presented on wr_*, waiting for wr_ready
module m2vblkwr #(
    parameter int MBX_WIDTH = 6,
    parameter int MBY_WIDTH = 5
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             block_start,
    input  logic [MBX_WIDTH-1:0]             s4_mb_x,
    input  logic [MBY_WIDTH-1:0]             s4_mb_y,
    input  logic [2:0]                       s4_block,
    input  logic                             s4_enable,
    input  logic [7:0]                       pix_data,
    input  logic                             pix_valid,
    output logic                             pix_ready,
    output logic [MBX_WIDTH+MBY_WIDTH+6:0]   wr_addr,
    output logic [31:0]                      wr_data,
    output logic                             wr_valid,
    input  logic                             wr_ready,
    output logic                             busy,
    output logic                             blk_done,
    output logic                             err_overrun
);
    localparam int AW = MBX_WIDTH + MBY_WIDTH + 7;

    typedef enum logic [1:0] {IDLE, COLLECT, FLUSH} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [5:0]           r_pix_cnt;
    logic [MBX_WIDTH-1:0] r_mb_x;
    logic [MBY_WIDTH-1:0] r_mb_y;
    logic [2:0]           r_block;
    logic [23:0]          r_pack;
    logic [31:0]          r_wr_data;
    logic [AW-1:0]        r_wr_addr;
    logic                 r_blk_done;
    logic                 r_err_overrun;

    logic                 w_start_ok;
    logic                 w_pix_acc;
    logic                 w_word_done;
    logic                 w_last;
    logic [3:0]           w_k;
    logic [2:0]           w_r;
    logic                 w_w;
    logic [AW-1:0]        w_addr_luma;
    logic [AW-1:0]        w_addr_chroma;

    assign w_start_ok  = block_start && s4_enable && (s4_block <= 3'd5);
    assign w_pix_acc   = pix_valid && pix_ready;
    assign w_word_done = w_pix_acc && (r_pix_cnt[1:0] == 2'd3);
    // pix_cnt has wrapped to zero once the 64th pixel has been taken
    assign w_last      = (r_pix_cnt == 6'd0);

    // Word index of the word being completed, split into row and half-row
    assign w_k = r_pix_cnt[5:2];
    assign w_r = w_k[3:1];
    assign w_w = w_k[0];

    // Multiplies by powers of two reduce to field concatenation
    assign w_addr_luma   = {1'b0, r_mb_y, r_block[1], w_r, r_mb_x, r_block[0], w_w};
    assign w_addr_chroma = {1'b1, 1'b0, r_block[0], r_mb_y, w_r, r_mb_x, w_w};

    assign busy        = (r_state != IDLE);
    assign wr_valid    = (r_state == FLUSH);
    assign pix_ready   = (r_state == COLLECT) && !wr_valid;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign blk_done    = r_blk_done;
    assign err_overrun = r_err_overrun;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start_ok)  w_state_nxt = COLLECT;
            COLLECT: if (w_word_done) w_state_nxt = FLUSH;
            FLUSH:   if (wr_ready)    w_state_nxt = w_last ? IDLE : COLLECT;
            default:                  w_state_nxt = IDLE;
        endcase
    end

    // Side-info latch, pixel packing, write word/address and status flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pix_cnt     <= '0;
            r_mb_x        <= '0;
            r_mb_y        <= '0;
            r_block       <= '0;
            r_pack        <= '0;
            r_wr_data     <= '0;
            r_wr_addr     <= '0;
            r_blk_done    <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            r_blk_done <= 1'b0;
            if (block_start && busy) r_err_overrun <= 1'b1;
            if (r_state == IDLE && block_start) begin
                if (w_start_ok) begin
                    r_mb_x    <= s4_mb_x;
                    r_mb_y    <= s4_mb_y;
                    r_block   <= s4_block;
                    r_pix_cnt <= '0;
                end else begin
                    r_blk_done <= 1'b1;
                end
            end
            if (w_pix_acc) begin
                r_pix_cnt <= r_pix_cnt + 6'd1;
                case (r_pix_cnt[1:0])
                    2'd0: r_pack[7:0]   <= pix_data;
                    2'd1: r_pack[15:8]  <= pix_data;
                    2'd2: r_pack[23:16] <= pix_data;
                    default: begin
                        r_wr_data <= {pix_data, r_pack};
                        r_wr_addr <= r_block[2] ? w_addr_chroma : w_addr_luma;
                    end
                endcase
            end
            if (r_state == FLUSH && wr_ready && w_last) r_blk_done <= 1'b1;
        end
    end
endmodule
